// File: rtl/xbar_arb_pkg.sv
// Shared types and default sizing for the crossbar job arbiter.
//   state_t        : arbiter FSM encoding (2-bit)
//   XBAR_ARB_NREQ  : default number of requesters
//   XBAR_ARB_IDX_W : default requester index width
package xbar_arb_pkg;

   localparam int unsigned XBAR_ARB_NREQ  = 4;
   localparam int unsigned XBAR_ARB_IDX_W = 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_WAIT    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/crossbar_job_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo NREQ. Kept standalone so other tile arbiters can reuse it.
//   req_i    : request vector
//   ptr_i    : round-robin start index (must be < NREQ)
//   win_c_o  : winning index (0 when none)
//   any_c_o  : at least one request set
module rr_pick #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] win_c_o,
   output logic             any_c_o
);

   // Scan offsets 0..NREQ-1 from the pointer; first hit wins.
   always_comb begin
      int unsigned k;
      logic        found;
      k       = 0;
      found   = 1'b0;
      win_c_o = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = 32'(ptr_i) + i;
         if (k >= NREQ) k = k - NREQ;
         if (!found && req_i[IDX_W'(k)]) begin
            win_c_o = IDX_W'(k);
            found   = 1'b1;
         end
      end
      any_c_o = found;
   end

endmodule

// File: rtl/crossbar_job_arbiter.sv
// Crossbar job arbiter: shares one crossbar tile between NREQ requesters.
// Grants round-robin, pulses xbar_start to the controller, waits for
// xbar_done, then pulses job_done to the owning requester.
// Optional watchdog: define XBAR_ARB_WATCHDOG_EN to end a job with job_err
// after WDOG_CYCLES cycles in S_WAIT without xbar_done.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req          : level requests, held until job_done
//   gnt/owner    : one-hot grant and index of holder (owner valid while busy)
//   busy         : tile allocated
//   xbar_start   : one-cycle start pulse to the crossbar controller
//   xbar_done    : one-cycle done pulse from the crossbar controller
//   job_done     : one-cycle completion pulse to the owner
//   job_err      : with job_done when the job ended by watchdog
//   stray_done   : sticky, xbar_done seen outside S_WAIT
module crossbar_job_arbiter
   import xbar_arb_pkg::*;
#(
   parameter int unsigned NREQ        = XBAR_ARB_NREQ,
   parameter int unsigned IDX_W       = XBAR_ARB_IDX_W,
   parameter int unsigned WDOG_CYCLES = 1023,
   parameter int unsigned WDOG_W      = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] owner,
   output logic             busy,
   output logic             xbar_start,
   input  logic             xbar_done,
   output logic [NREQ-1:0]  job_done,
   output logic             job_err,
   output logic             stray_done
);

   state_t             state_q, state_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               busy_q, busy_d;
   logic               xbar_start_q, xbar_start_d;
   logic [NREQ-1:0]    job_done_q, job_done_d;
   logic               stray_q, stray_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;

   logic [IDX_W-1:0]   pick_win;
   logic               pick_any;
   logic               finish_c;
   logic               timeout_c;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .win_c_o (pick_win),
      .any_c_o (pick_any)
   );

`ifdef XBAR_ARB_WATCHDOG_EN
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              job_err_q, job_err_d;

   // Expiry on the WDOG_CYCLES-th wait cycle; a coincident done wins.
   assign timeout_c = (state_q == S_WAIT) && !xbar_done &&
                      (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
`else
   logic [WDOG_W-1:0] wdog_unused;
   assign wdog_unused = WDOG_W'(WDOG_CYCLES);
   assign timeout_c   = 1'b0;
`endif

   assign finish_c = (state_q == S_WAIT) && (xbar_done || timeout_c);

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      owner_d      = owner_q;
      busy_d       = busy_q;
      ptr_d        = ptr_q;
      xbar_start_d = 1'b0;
      job_done_d   = '0;
      stray_d      = stray_q | (xbar_done & (state_q != S_WAIT));
`ifdef XBAR_ARB_WATCHDOG_EN
      wdog_d       = wdog_q;
      job_err_d    = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               gnt_d   = NREQ'(1) << pick_win;
               owner_d = pick_win;
               busy_d  = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            xbar_start_d = 1'b1;
            state_d      = S_WAIT;
`ifdef XBAR_ARB_WATCHDOG_EN
            wdog_d       = '0;
`endif
         end
         S_WAIT: begin
            if (finish_c) begin
               job_done_d = NREQ'(1) << owner_q;
               gnt_d      = '0;
               busy_d     = 1'b0;
               ptr_d      = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
               state_d    = S_RELEASE;
`ifdef XBAR_ARB_WATCHDOG_EN
               job_err_d  = timeout_c;
`endif
            end
`ifdef XBAR_ARB_WATCHDOG_EN
            else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
`endif
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         gnt_q        <= '0;
         owner_q      <= '0;
         busy_q       <= 1'b0;
         ptr_q        <= '0;
         xbar_start_q <= 1'b0;
         job_done_q   <= '0;
         stray_q      <= 1'b0;
`ifdef XBAR_ARB_WATCHDOG_EN
         wdog_q       <= '0;
         job_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         owner_q      <= owner_d;
         busy_q       <= busy_d;
         ptr_q        <= ptr_d;
         xbar_start_q <= xbar_start_d;
         job_done_q   <= job_done_d;
         stray_q      <= stray_d;
`ifdef XBAR_ARB_WATCHDOG_EN
         wdog_q       <= wdog_d;
         job_err_q    <= job_err_d;
`endif
      end
   end

   assign gnt        = gnt_q;
   assign owner      = owner_q;
   assign busy       = busy_q;
   assign xbar_start = xbar_start_q;
   assign job_done   = job_done_q;
   assign stray_done = stray_q;
`ifdef XBAR_ARB_WATCHDOG_EN
   assign job_err    = job_err_q;
`else
   assign job_err    = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_job_arbiter.sv
// Self-checking bench for crossbar_job_arbiter (NREQ=4). Expected job
// completions are queued when a job is launched and compared when job_done
// pulses. Define XBAR_ARB_WATCHDOG_EN to also exercise the watchdog (8 cycles).
module tb_crossbar_job_arbiter;

`ifdef XBAR_ARB_WATCHDOG_EN
   localparam int unsigned WDOG = 8;
`else
   localparam int unsigned WDOG = 1023;
`endif

   typedef struct packed {
      logic [3:0] oh;
      logic       err;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic       busy;
   logic       xbar_start;
   logic       xbar_done;
   logic [3:0] job_done;
   logic       job_err;
   logic       stray_done;

   int   n_checks;
   int   n_errors;
   exp_t sb_q[$];
   exp_t mon_e;

   crossbar_job_arbiter #(
      .NREQ        (4),
      .IDX_W       (2),
      .WDOG_CYCLES (WDOG),
      .WDOG_W      (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .gnt        (gnt),
      .owner      (owner),
      .busy       (busy),
      .xbar_start (xbar_start),
      .xbar_done  (xbar_done),
      .job_done   (job_done),
      .job_err    (job_err),
      .stray_done (stray_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard: every job_done pulse must match the oldest queued job.
   always @(negedge clk) begin
      if (!rst && (job_done != 4'b0 || job_err)) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'(job_done), 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_job_done", 32'(job_done), 32'(mon_e.oh));
            check("sb_job_err", 32'(job_err), 32'(mon_e.err));
         end
      end
   end

   task automatic wait_start();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (xbar_start !== 1'b1 && n < 20);
      check("start_seen", 32'(xbar_start), 32'h1);
   endtask

   // Launch a job, check the grant, finish it dly cycles after start.
   task automatic run_job(input logic [3:0] rv, input int exp_owner, input int dly, input bit drop);
      logic [3:0] oh;
      oh  = 4'(1) << exp_owner;
      req = rv;
      sb_q.push_back('{oh: oh, err: 1'b0});
      wait_start();
      check("job_gnt", 32'(gnt), 32'(oh));
      check("job_owner", 32'(owner), 32'(exp_owner));
      check("job_busy", 32'(busy), 32'h1);
      repeat (dly) @(negedge clk);
      xbar_done = 1'b1;
      @(negedge clk);
      xbar_done = 1'b0;
      check("rel_gnt", 32'(gnt), 32'h0);
      check("rel_busy", 32'(busy), 32'h0);
      if (drop) req = 4'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      req       = 4'b0;
      xbar_done = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_start", 32'(xbar_start), 32'h0);
      check("rst_job_done", 32'(job_done), 32'h0);
      check("rst_job_err", 32'(job_err), 32'h0);
      check("rst_stray", 32'(stray_done), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // All requesting: order 0,1,2,3,0
      run_job(4'b1111, 0, 5, 1'b0);
      run_job(4'b1111, 1, 5, 1'b0);
      run_job(4'b1111, 2, 5, 1'b0);
      run_job(4'b1111, 3, 5, 1'b0);
      run_job(4'b1111, 0, 5, 1'b1);

      // Single requester latency (pointer is 1, so this also wraps)
      @(negedge clk);
      req = 4'b0001;
      sb_q.push_back('{oh: 4'b0001, err: 1'b0});
      @(negedge clk);
      check("s1_gnt_t1", 32'(gnt), 32'h1);
      check("s1_owner_t1", 32'(owner), 32'h0);
      check("s1_busy_t1", 32'(busy), 32'h1);
      check("s1_start_t1", 32'(xbar_start), 32'h0);
      @(negedge clk);
      check("s1_start_t2", 32'(xbar_start), 32'h1);
      @(negedge clk);
      check("s1_start_t3", 32'(xbar_start), 32'h0);
      check("s1_gnt_t3", 32'(gnt), 32'h1);
      repeat (5) @(negedge clk);
      xbar_done = 1'b1;
      @(negedge clk);
      xbar_done = 1'b0;
      check("s1_job_done", 32'(job_done), 32'h1);
      check("s1_gnt_rel", 32'(gnt), 32'h0);
      check("s1_busy_rel", 32'(busy), 32'h0);
      req = 4'b0;
      @(negedge clk);
      check("s1_job_done_off", 32'(job_done), 32'h0);
      @(negedge clk);
      check("s1_no_regrant", 32'(gnt), 32'h0);

      // Wrap and skip: pointer to 3, then req 0101 -> 0 then 2
      run_job(4'b0100, 2, 3, 1'b1);
      run_job(4'b0101, 0, 3, 1'b0);
      run_job(4'b0101, 2, 3, 1'b1);

      // Owner NREQ-1 wraps pointer to 0
      run_job(4'b1000, 3, 2, 1'b1);
      run_job(4'b1001, 0, 2, 1'b1);

      // Abandon: owner drops req in S_WAIT, job_done still pulses
      req = 4'b0010;
      sb_q.push_back('{oh: 4'b0010, err: 1'b0});
      wait_start();
      check("ab_owner", 32'(owner), 32'h1);
      req = 4'b0;
      repeat (3) @(negedge clk);
      check("ab_still_busy", 32'(busy), 32'h1);
      xbar_done = 1'b1;
      @(negedge clk);
      xbar_done = 1'b0;
      check("ab_job_done", 32'(job_done), 32'h2);
      @(negedge clk);

      // Stray done in S_IDLE
      check("stray_pre", 32'(stray_done), 32'h0);
      xbar_done = 1'b1;
      @(negedge clk);
      xbar_done = 1'b0;
      check("stray_set", 32'(stray_done), 32'h1);
      check("stray_gnt", 32'(gnt), 32'h0);
      check("stray_busy", 32'(busy), 32'h0);
      @(negedge clk);
      check("stray_sticky", 32'(stray_done), 32'h1);
      check("stray_job_done", 32'(job_done), 32'h0);

      // Reset mid-job (pointer is 2 here)
      req = 4'b1000;
      wait_start();
      check("rm_owner", 32'(owner), 32'h3);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rm_gnt", 32'(gnt), 32'h0);
      check("rm_owner0", 32'(owner), 32'h0);
      check("rm_busy", 32'(busy), 32'h0);
      check("rm_start", 32'(xbar_start), 32'h0);
      check("rm_stray", 32'(stray_done), 32'h0);
      @(negedge clk);
      xbar_done = 1'b1;
      @(negedge clk);
      xbar_done = 1'b0;
      check("rm_late_stray", 32'(stray_done), 32'h1);
      check("rm_late_gnt", 32'(gnt), 32'h0);
      check("rm_late_job_done", 32'(job_done), 32'h0);
      run_job(4'b1111, 0, 4, 1'b1);

`ifdef XBAR_ARB_WATCHDOG_EN
      // Watchdog expiry after 8 wait cycles
      @(negedge clk);
      req = 4'b0001;
      sb_q.push_back('{oh: 4'b0001, err: 1'b1});
      wait_start();
      repeat (7) @(negedge clk);
      check("wd_not_yet", 32'(job_done), 32'h0);
      @(negedge clk);
      check("wd_job_done", 32'(job_done), 32'h1);
      check("wd_job_err", 32'(job_err), 32'h1);
      req = 4'b0;
      @(negedge clk);
      check("wd_err_clear", 32'(job_err), 32'h0);

      // Done coincident with expiry: done wins
      req = 4'b0010;
      sb_q.push_back('{oh: 4'b0010, err: 1'b0});
      wait_start();
      repeat (7) @(negedge clk);
      xbar_done = 1'b1;
      @(negedge clk);
      xbar_done = 1'b0;
      check("wd_co_job_done", 32'(job_done), 32'h2);
      check("wd_co_job_err", 32'(job_err), 32'h0);
      req = 4'b0;
`endif

      repeat (3) @(negedge clk);
      check("sb_leftover", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
